// File: rtl/pwm_tick_gen.sv
// pwm_tick_gen: edge-detects clk_div_in into step strobes driving a PWM counter with shadowed period/duty.
module pwm_tick_gen #(
  parameter int WIDTH = 8,
  parameter int unsigned DEFAULT_PERIOD = 255,
  parameter int unsigned DEFAULT_DUTY = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_div_in,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic [WIDTH-1:0] cfg_duty,
  output logic             cfg_ready,
  output logic             tick,
  output logic             period_start,
  output logic             pwm_out
);
  logic div_q, pending, step, wrap, load, accept;
  logic [WIDTH-1:0] cnt, period_act, duty_act, shadow_period, shadow_duty, cnt_next, duty_next;
  always_comb begin
    step = clk_div_in & ~div_q;
    wrap = cnt == period_act;
    cnt_next = wrap ? '0 : cnt + WIDTH'(1);
    load = step & wrap & pending;
    duty_next = load ? shadow_duty : duty_act;
    accept = cfg_valid & cfg_ready;
  end
  always_ff @(posedge clk)
    if (reset) begin
      div_q <= 1'b1;
      cnt <= '0;
      period_act <= WIDTH'(DEFAULT_PERIOD);
      duty_act <= WIDTH'(DEFAULT_DUTY);
      shadow_period <= '0;
      shadow_duty <= '0;
      pending <= 1'b0;
      cfg_ready <= 1'b1;
      tick <= 1'b0;
      period_start <= 1'b0;
      pwm_out <= 1'b0;
    end else begin
      div_q <= clk_div_in;
      tick <= step;
      period_start <= step & wrap;
      if (step) begin
        cnt <= cnt_next;
        pwm_out <= cnt_next < duty_next;
      end
      if (load) begin
        period_act <= shadow_period;
        duty_act <= shadow_duty;
      end
      if (accept) begin
        shadow_period <= cfg_period;
        shadow_duty <= cfg_duty;
      end
      pending <= accept | (pending & ~load);
      cfg_ready <= ~(accept | (pending & ~load));
    end
endmodule

// File: tb/tb_pwm_tick_gen.sv
// tb_pwm_tick_gen: directed vectors and hand sequences for pwm_tick_gen.
module tb_pwm_tick_gen;
  logic clk = 0, reset = 1, clk_div_in = 1, cfg_valid = 0;
  logic [7:0] cfg_period = 0, cfg_duty = 0;
  logic cfg_ready, tick, period_start, pwm_out;
  int n_cmp = 0, n_bad = 0, tick_miss = 0, pulse_err = 0;

  pwm_tick_gen dut (
    .clk(clk), .reset(reset), .clk_div_in(clk_div_in), .cfg_valid(cfg_valid),
    .cfg_period(cfg_period), .cfg_duty(cfg_duty), .cfg_ready(cfg_ready),
    .tick(tick), .period_start(period_start), .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] period;
    logic [7:0] duty;
    logic [7:0] exp_pwm;
    logic [7:0] exp_ps;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clk_div_in period of 4 clk; outputs sampled 1 clk after the sampled rise.
  task automatic do_step(output logic t, output logic p, output logic s, output logic r);
    @(posedge clk); #1 clk_div_in = 1;
    @(posedge clk); #1 t = tick; p = pwm_out; s = period_start; r = cfg_ready;
    @(posedge clk); #1 if (tick || period_start) pulse_err++;
    clk_div_in = 0;
    @(posedge clk); #1;
  endtask

  task automatic cfg_send(input logic [7:0] per, input logic [7:0] dty);
    int n = 0;
    logic r;
    cfg_period = per; cfg_duty = dty; cfg_valid = 1;
    do begin
      r = cfg_ready;
      @(posedge clk); #1;
      n++;
    end while (!r && n < 50);
    cfg_valid = 0;
    chk("cfg_accepted", r, 1);
    chk("ready_low_after_accept", cfg_ready, 0);
  endtask

  task automatic wait_wrap(output logic found, output logic p, output logic ready_at, output int early);
    logic t, s, r;
    found = 0; p = 0; ready_at = 0; early = 0;
    for (int k = 0; k < 300 && !found; k++) begin
      do_step(t, p, s, r);
      if (!t) tick_miss++;
      if (s) begin
        found = 1;
        ready_at = r;
      end else if (r) early++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic t, p, s, r, found, rdy;
    int early, highs, ps_cnt, ps_last, ticks, chg;
    logic p127, p128, p_hold;
    logic [7:0] pv, sv;
    logic [8:0] pv9, sv9;
    vecs[0] = '{8'd3, 8'd1, 8'b00010001, 8'b00010001};
    vecs[1] = '{8'd0, 8'd0, 8'h00,       8'hFF};
    vecs[2] = '{8'd4, 8'd0, 8'h00,       8'b00100001};
    vecs[3] = '{8'd4, 8'd9, 8'hFF,       8'b00100001};
    vecs[4] = '{8'd4, 8'd2, 8'b01100011, 8'b00100001};
    vecs[5] = '{8'd0, 8'd5, 8'hFF,       8'hFF};

    // Reset release with clk_div_in high must not produce a tick
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(posedge clk); #1;
    chk("rst_tick", tick, 0);
    chk("rst_pwm", pwm_out, 0);
    chk("rst_ps", period_start, 0);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_cnt", dut.cnt, 0);
    clk_div_in = 0;

    // Defaults: period 255, duty 128
    highs = 0; ps_cnt = 0; ps_last = 0; ticks = 0; p127 = 0; p128 = 1;
    for (int k = 1; k <= 256; k++) begin
      do_step(t, p, s, r);
      ticks += int'(t);
      highs += int'(p);
      if (s) begin ps_cnt++; ps_last = k; end
      if (k == 127) p127 = p;
      if (k == 128) p128 = p;
    end
    chk("def_ticks", ticks, 256);
    chk("def_highs", highs, 128);
    chk("def_ps_count", ps_cnt, 1);
    chk("def_ps_pos", ps_last, 256);
    chk("def_pwm_step127", p127, 1);
    chk("def_pwm_step128", p128, 0);

    // Move to mid-period before the first table config
    do_step(t, p, s, r);
    for (int i = 0; i < 6; i++) begin
      cfg_send(vecs[i].period, vecs[i].duty);
      wait_wrap(found, p, rdy, early);
      chk($sformatf("v%0d_wrap_found", i), found, 1);
      chk($sformatf("v%0d_ready_held_low", i), early, 0);
      chk($sformatf("v%0d_ready_at_apply", i), rdy, 1);
      pv = '0; sv = '0;
      pv[0] = p; sv[0] = found;
      for (int j = 1; j < 8; j++) begin
        do_step(t, p, s, r);
        if (!t) tick_miss++;
        pv[j] = p; sv[j] = s;
      end
      chk($sformatf("v%0d_pwm_pattern", i), pv, vecs[i].exp_pwm);
      chk($sformatf("v%0d_ps_pattern", i), sv, vecs[i].exp_ps);
    end

    // Config accepted on the exact wrap step applies one period later
    cfg_send(8'd3, 8'd1);
    wait_wrap(found, p, rdy, early);
    chk("sim_setup_wrap", found, 1);
    repeat (3) do_step(t, p, s, r);
    @(posedge clk); #1 clk_div_in = 1; cfg_period = 4; cfg_duty = 2; cfg_valid = 1;
    @(posedge clk); #1 cfg_valid = 0;
    chk("sim_ps", period_start, 1);
    chk("sim_pwm", pwm_out, 1);
    chk("sim_ready", cfg_ready, 0);
    @(posedge clk); #1 clk_div_in = 0;
    @(posedge clk); #1;
    pv9 = '0; sv9 = '0;
    for (int j = 0; j < 9; j++) begin
      do_step(t, p, s, r);
      pv9[j] = p; sv9[j] = s;
    end
    chk("sim_pwm_pattern", pv9, 9'b100011000);
    chk("sim_ps_pattern", sv9, 9'b100001000);

    // clk_div_in held high: exactly one tick, then everything holds
    @(posedge clk); #1 clk_div_in = 1;
    ticks = 0; chg = 0;
    @(posedge clk); #1 ticks += int'(tick);
    p_hold = pwm_out;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      ticks += int'(tick) + int'(period_start);
      if (pwm_out !== p_hold) chg++;
    end
    chk("hold_ticks", ticks, 1);
    chk("hold_pwm_stable", chg, 0);
    clk_div_in = 0;

    // Reset while a config is pending and cnt=5
    cfg_send(8'd9, 8'd9);
    wait_wrap(found, p, rdy, early);
    repeat (5) do_step(t, p, s, r);
    cfg_send(8'd2, 8'd1);
    chk("pre_rst_cnt", dut.cnt, 5);
    chk("pre_rst_pwm", pwm_out, 1);
    reset = 1;
    @(posedge clk); #1;
    chk("mid_rst_cnt", dut.cnt, 0);
    chk("mid_rst_pending", dut.pending, 0);
    chk("mid_rst_ready", cfg_ready, 1);
    chk("mid_rst_pwm", pwm_out, 0);
    chk("mid_rst_period", dut.period_act, 255);
    chk("mid_rst_duty", dut.duty_act, 128);
    reset = 0;
    @(posedge clk); #1;

    chk("tick_every_step", tick_miss, 0);
    chk("single_cycle_pulses", pulse_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pwm_tick_gen.md
Name: pwm_tick_gen

Overview:
Downstream consumer of the divided clock produced by the team's clock divider (clk_div_2n). Edge-detects the divided clock in the fast clk domain to form single-cycle step strobes. It drives a PWM counter from those strobes. Period and duty are loaded through a valid/ready port and applied glitch-free at the period boundary.

Parameters:
WIDTH, 8, width of counter, period and duty
DEFAULT_PERIOD, 255, active period value after reset (period length = value+1 steps)
DEFAULT_DUTY, 128, active duty value after reset (high steps per period)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high
clk_div_in  input  1  divided clock from upstream divider, generated in the clk domain
cfg_valid  input  1  new period/duty offered
cfg_period  input  WIDTH  requested period value
cfg_duty  input  WIDTH  requested duty value
cfg_ready  output  1  shadow register free; accepts config this cycle
tick  output  1  registered one-cycle pulse per rising edge of clk_div_in
period_start  output  1  registered one-cycle pulse when the counter wraps to 0
pwm_out  output  1  registered PWM output

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset values:
  - div_q=1 (suppresses a false edge if clk_div_in is high at release)
  - cnt=0, period_act=DEFAULT_PERIOD, duty_act=DEFAULT_DUTY, pending=0
  - tick=0, period_start=0, pwm_out=0, cfg_ready=1 (registered, from ~pending)
- Edge detect:
  - div_q<=clk_div_in every cycle.
  - step = clk_div_in & ~div_q (combinational, internal).
  - tick<=step, so tick is one cycle after the cycle where the edge is sampled.
- Counter, advanced only when step=1:
  - If cnt==period_act: cnt_next=0 (wrap); otherwise cnt_next=cnt+1.
  - When step=0: cnt, pwm_out and the active registers hold.
  - period_start<=step & wrap. It is 0 on all other cycles.
- Shadow load at wrap: on a step with wrap and pending=1:
  - period_act<=shadow_period, duty_act<=shadow_duty, pending<=0.
  - pwm_out is evaluated with the new values.
- PWM output, on step:
  - pwm_out<=(cnt_next < duty_next). duty_next is the shadow value when loading this step, otherwise duty_act.
  - Comparison is unsigned, WIDTH bits.
  - duty=0 gives a constant 0. duty>period gives a constant 1 (no glitch at wrap).
- period_act=0: every step wraps, so cnt stays 0, period_start pulses on every step, and pwm_out=(duty_act!=0).
- Config handshake:
  - Transfer when cfg_valid & cfg_ready. Capture cfg_period/cfg_duty into the shadow and set pending<=1.
  - cfg_ready<=~pending_next. It is low from the cycle after acceptance until the cycle after the applying wrap.
  - While cfg_ready=0, cfg_valid is ignored; the upstream must hold its request.
- Simultaneous events:
  - Acceptance in the same cycle as a wrap step captures the shadow only. The new values apply at the following wrap.
  - pending has no effect until a wrap step occurs.
- Reset mid-operation: all state returns to reset values on the next edge. A pending config is discarded.
- clk_div_in held constant: no steps, so all outputs hold (tick=0, period_start=0).
- Latency: pwm_out, tick and period_start change in the same cycle, exactly 1 clk after the sampled rising edge of clk_div_in.

Test Plan:
- Reset release with clk_div_in=1 -> no tick in the first cycle. Outputs 0, cfg_ready=1, cnt=0.
- Defaults with clk_div_in toggling every 2 clk -> tick every 4 clk. pwm_out high for 128 steps and low for 128. period_start every 256 ticks.
- cfg period=3 duty=1 accepted mid-period -> cfg_ready=0 until the wrap. Then the pattern is high 1 step, low 3 steps. period_start every 4 ticks, cfg_ready=1 the cycle after the wrap.
- Config accepted on the exact wrap step (period=4 duty=2) -> the old pattern continues for one more full period, then 2 high / 3 low.
- Corner values:
  - period=0, duty=0 -> pwm_out constantly 0, period_start on every tick.
  - duty=0 with period=4 -> pwm_out constantly 0.
  - duty=9 with period=4 -> pwm_out constantly 1, no dropout at wrap.
- Reset asserted while pending=1 and cnt=5 -> the next cycle shows cnt=0, defaults restored, pending cleared, cfg_ready=1, pwm_out=0.
